cr_isf_fifo_ia_ctl: RTL and testbench

CR_ISF_FIFO_IA_CTL -- requirements
Module: cr_isf_fifo_ia_ctl

---
 rtl/cr_isf_fifo_ia_ctl_pkg.sv | 34 +++
 rtl/cr_isf_fifo_ia_ctl_if.sv | 31 +++
 rtl/cr_isf_fifo_ia_ctl.sv | 118 +++++++++++
 tb/tb_cr_isf_fifo_ia_ctl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cr_isf_fifo_ia_ctl_pkg.sv
// Shared types for the ISF FIFO indirect-access controller: opcodes, FSM states
// and the packed status word returned to the register file.
package cr_isfPKG;

    typedef enum logic [3:0] {
        OP_NOP     = 4'd0,
        OP_READ    = 4'd1,
        OP_WRITE   = 4'd2,
        OP_ENABLE  = 4'd3,
        OP_DISABLE = 4'd4,
        OP_INIT    = 4'd5
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        RD_WAIT,
        INIT,
        DONE
    } state_e;

    typedef struct packed {
        logic       busy;
        logic       err;
        logic       fifo_en;
        logic       rsvd;
        logic [3:0] last_op;
    } ia_status_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        return op <= 4'd5;
    endfunction

endpackage

// File: rtl/cr_isf_fifo_ia_ctl_if.sv
// Bundle of config, datapath-arbitration and memory-port signals around the
// IA controller; the controller sits on the slave side.
interface cr_isf_fifo_ia_ctl_if #(
    parameter int N_ADDR_BITS = 10,
    parameter int N_DATA_BITS = 96
);
    logic                   cfg_stb;
    logic [3:0]             cfg_op;
    logic [N_ADDR_BITS-1:0] cfg_addr;
    logic [N_DATA_BITS-1:0] ia_wdata;
    logic                   dp_req;
    logic                   dp_gnt;
    logic                   mem_en;
    logic                   mem_wr;
    logic [N_ADDR_BITS-1:0] mem_addr;
    logic [N_DATA_BITS-1:0] mem_wdata;
    logic [N_DATA_BITS-1:0] mem_rdata;
    logic [N_DATA_BITS-1:0] ia_rdata;
    logic [7:0]             ia_status;
    logic                   fifo_en;

    modport master (
        output cfg_stb, cfg_op, cfg_addr, ia_wdata, dp_req, mem_rdata,
        input  dp_gnt, mem_en, mem_wr, mem_addr, mem_wdata, ia_rdata, ia_status, fifo_en
    );

    modport slave (
        input  cfg_stb, cfg_op, cfg_addr, ia_wdata, dp_req, mem_rdata,
        output dp_gnt, mem_en, mem_wr, mem_addr, mem_wdata, ia_rdata, ia_status, fifo_en
    );
endinterface

// File: rtl/cr_isf_fifo_ia_ctl.sv
// Indirect-access controller for the ISF FIFO memory: serialises register-file
// READ/WRITE/INIT commands onto the memory port, yielding to the datapath.
module cr_isf_fifo_ia_ctl
    import cr_isfPKG::*;
#(
    parameter int N_ADDR_BITS = 10,
    parameter int N_DATA_BITS = 96
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cr_isf_fifo_ia_ctl_if.slave  bus
);

    localparam logic [N_ADDR_BITS-1:0] CNT_MAX = '1;

    state_e                 state_q;
    op_e                    op_q;
    logic [N_ADDR_BITS-1:0] addr_q;
    logic [N_DATA_BITS-1:0] wdata_q;
    logic [N_ADDR_BITS-1:0] cnt_q;
    logic                   busy_q;
    logic                   err_q;
    logic                   fifo_en_q;
    logic [3:0]             last_op_q;
    logic [N_DATA_BITS-1:0] ia_rdata_q;

    logic       arb_go_d;
    logic       in_init_d;
    ia_status_t status_d;

    // INIT owns the port outright; READ/WRITE get exactly one access slot in ARB
    // once the datapath lets go.
    assign in_init_d = (state_q == INIT);
    assign arb_go_d  = (state_q == ARB) && !bus.dp_req && (op_q != OP_INIT);

    assign bus.dp_gnt    = bus.dp_req && !in_init_d;
    assign bus.mem_en    = arb_go_d || in_init_d;
    assign bus.mem_wr    = (arb_go_d && (op_q == OP_WRITE)) || in_init_d;
    assign bus.mem_addr  = in_init_d ? cnt_q : (arb_go_d ? addr_q : '0);
    assign bus.mem_wdata = arb_go_d ? wdata_q : '0;

    assign status_d      = {busy_q, err_q, fifo_en_q, 1'b0, last_op_q};
    assign bus.ia_status = status_d;
    assign bus.fifo_en   = fifo_en_q;
    assign bus.ia_rdata  = ia_rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= OP_NOP;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            fifo_en_q  <= 1'b0;
            last_op_q  <= 4'd0;
            ia_rdata_q <= '0;
        end else begin
            if (bus.cfg_stb && (state_q != IDLE)) begin
                err_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (bus.cfg_stb) begin
                        if (!op_is_legal(bus.cfg_op)) begin
                            err_q <= 1'b1;
                        end else begin
                            err_q     <= 1'b0;
                            last_op_q <= bus.cfg_op;
                            case (bus.cfg_op)
                                OP_READ, OP_WRITE, OP_INIT: begin
                                    op_q    <= op_e'(bus.cfg_op);
                                    addr_q  <= bus.cfg_addr;
                                    wdata_q <= bus.ia_wdata;
                                    busy_q  <= 1'b1;
                                    state_q <= ARB;
                                end
                                OP_ENABLE:  fifo_en_q <= 1'b1;
                                OP_DISABLE: fifo_en_q <= 1'b0;
                                default: ;
                            endcase
                        end
                    end
                end
                ARB: begin
                    // INIT takes the port from the datapath, so it never waits here.
                    if (op_q == OP_INIT) begin
                        cnt_q     <= '0;
                        fifo_en_q <= 1'b0;
                        state_q   <= INIT;
                    end else if (!bus.dp_req) begin
                        state_q <= (op_q == OP_READ) ? RD_WAIT : DONE;
                    end
                end
                RD_WAIT: begin
                    ia_rdata_q <= bus.mem_rdata;
                    state_q    <= DONE;
                end
                INIT: begin
                    fifo_en_q <= 1'b0;
                    if (cnt_q == CNT_MAX) begin
                        cnt_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cr_isf_fifo_ia_ctl.sv
// Directed + randomized bench for the IA controller, checked against a
// command-level model of memory contents and status bits.
module tb_cr_isf_fifo_ia_ctl;
    import cr_isfPKG::*;

    localparam int AW    = 10;
    localparam int DW    = 96;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] tbMem  [DEPTH];
    logic [DW-1:0] refMem [DEPTH];
    logic          refFifo = 1'b0;
    logic          seeded = 1'b0;

    logic monitorOn = 1'b0;
    int   sweepWrites = 0;
    int   sweepBad = 0;
    int   sweepGaps = 0;
    int   sweepGnt = 0;
    int   overlapViol = 0;

    cr_isf_fifo_ia_ctl_if #(.N_ADDR_BITS(AW), .N_DATA_BITS(DW)) bus();

    cr_isf_fifo_ia_ctl #(.N_ADDR_BITS(AW), .N_DATA_BITS(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] seedPattern(input int i);
        return {32'(i) ^ 32'hC0DE_0000, ~32'(i), 32'(i) * 32'd7 + 32'd3};
    endfunction

    // Memory model: read data appears one cycle after the access, junk otherwise.
    always @(posedge clk) begin
        if (!rst_n && !seeded) begin
            for (int i = 0; i < DEPTH; i++) tbMem[i] <= seedPattern(i);
            seeded <= 1'b1;
        end
        if (bus.mem_en && bus.mem_wr) tbMem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_en && !bus.mem_wr) bus.mem_rdata <= tbMem[bus.mem_addr];
        else bus.mem_rdata <= {$urandom, $urandom, $urandom};
    end

    // Sweep monitor: tracks INIT write sequence and port-sharing violations.
    always @(negedge clk) begin
        if (bus.mem_en && bus.dp_gnt) overlapViol++;
        if (!monitorOn) begin
            sweepWrites = 0;
            sweepBad    = 0;
            sweepGaps   = 0;
            sweepGnt    = 0;
        end else begin
            if (bus.mem_en) begin
                if (!bus.mem_wr || bus.mem_wdata != '0 || int'(bus.mem_addr) != sweepWrites) sweepBad++;
                sweepWrites++;
            end else if (sweepWrites > 0 && sweepWrites < DEPTH) begin
                sweepGaps++;
            end
            if (sweepWrites > 0 && sweepWrites < DEPTH && bus.dp_gnt) sweepGnt++;
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        @(negedge clk);
        bus.cfg_stb  = 1'b1;
        bus.cfg_op   = op;
        bus.cfg_addr = addr;
        bus.ia_wdata = data;
        @(negedge clk);
        bus.cfg_stb  = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (bus.ia_status[7] !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle_within_budget", 128'(n < budget), 128'(1));
    endtask

    function automatic logic [7:0] expStatus(input logic err, input logic [3:0] lastOp);
        return {1'b0, err, refFifo, 1'b0, lastOp};
    endfunction

    initial begin
        logic [3:0]    opTable [5];
        logic [3:0]    op;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            dpHold;
        logic          found;

        opTable = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        for (int i = 0; i < DEPTH; i++) refMem[i] = seedPattern(i);
        bus.cfg_stb  = 1'b0;
        bus.cfg_op   = 4'd0;
        bus.cfg_addr = '0;
        bus.ia_wdata = '0;
        bus.dp_req   = 1'b1;

        // Reset state, with dp_gnt following dp_req.
        repeat (3) @(negedge clk);
        checkOutput("rst_status", 128'(bus.ia_status), 128'(0));
        checkOutput("rst_rdata", 128'(bus.ia_rdata), 128'(0));
        checkOutput("rst_mem_en", 128'(bus.mem_en), 128'(0));
        checkOutput("rst_mem_addr", 128'(bus.mem_addr), 128'(0));
        checkOutput("rst_gnt_hi", 128'(bus.dp_gnt), 128'(1));
        bus.dp_req = 1'b0;
        #1 checkOutput("rst_gnt_lo", 128'(bus.dp_gnt), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // WRITE with no contention: access on the next cycle, idle two later.
        data = {12{8'hA5}};
        applyStimulus(4'd2, 10'h005, data);
        checkOutput("wr_mem_en", 128'(bus.mem_en), 128'(1));
        checkOutput("wr_mem_wr", 128'(bus.mem_wr), 128'(1));
        checkOutput("wr_mem_addr", 128'(bus.mem_addr), 128'(5));
        checkOutput("wr_mem_wdata", 128'(bus.mem_wdata), 128'(data));
        checkOutput("wr_busy", 128'(bus.ia_status[7]), 128'(1));
        refMem[5] = data;
        repeat (2) @(negedge clk);
        checkOutput("wr_done_status", 128'(bus.ia_status), 128'(expStatus(1'b0, 4'd2)));
        checkOutput("wr_mem_content", 128'(tbMem[5]), 128'(data));

        // READ back: data lands two cycles after the read access.
        applyStimulus(4'd1, 10'h005, '0);
        checkOutput("rd_mem_en", 128'(bus.mem_en), 128'(1));
        checkOutput("rd_mem_wr", 128'(bus.mem_wr), 128'(0));
        repeat (2) @(negedge clk);
        checkOutput("rd_rdata", 128'(bus.ia_rdata), 128'(refMem[5]));
        waitIdle(10);
        checkOutput("rd_status", 128'(bus.ia_status), 128'(expStatus(1'b0, 4'd1)));

        // READ blocked by the datapath for five cycles.
        bus.dp_req = 1'b1;
        applyStimulus(4'd1, 10'h005, '0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("blk_no_mem_en", 128'(bus.mem_en), 128'(0));
            checkOutput("blk_gnt", 128'(bus.dp_gnt), 128'(1));
            if (i < 4) @(negedge clk);
        end
        @(negedge clk);
        bus.dp_req = 1'b0;
        #1 checkOutput("blk_release_mem_en", 128'(bus.mem_en), 128'(1));
        checkOutput("blk_release_addr", 128'(bus.mem_addr), 128'(5));
        waitIdle(10);
        checkOutput("blk_rdata", 128'(bus.ia_rdata), 128'(refMem[5]));

        // Randomized command stream against the reference model.
        for (int it = 0; it < 40; it++) begin
            op     = opTable[$urandom_range(0, 4)];
            addr   = AW'($urandom_range(0, 15));
            data   = {$urandom, $urandom, $urandom};
            dpHold = $urandom_range(0, 3);
            bus.dp_req = (dpHold > 0);
            applyStimulus(op, addr, data);
            if (op == 4'd3 || op == 4'd4 || op == 4'd0) begin
                if (op == 4'd3) refFifo = 1'b1;
                if (op == 4'd4) refFifo = 1'b0;
                checkOutput("rnd_noop_busy", 128'(bus.ia_status[7]), 128'(0));
            end
            if (dpHold > 0) repeat (dpHold) @(negedge clk);
            bus.dp_req = 1'b0;
            waitIdle(20);
            if (op == 4'd2) begin
                refMem[addr] = data;
                checkOutput("rnd_wr_content", 128'(tbMem[addr]), 128'(data));
            end
            if (op == 4'd1) checkOutput("rnd_rd_data", 128'(bus.ia_rdata), 128'(refMem[addr]));
            checkOutput("rnd_status", 128'(bus.ia_status), 128'(expStatus(1'b0, op)));
            checkOutput("rnd_fifo_en", 128'(bus.fifo_en), 128'(refFifo));
        end

        // Strobe while busy, then an illegal opcode, then a clearing NOP.
        applyStimulus(4'd1, 10'h005, '0);
        applyStimulus(4'd2, 10'h006, {3{32'h1234_5678}});
        checkOutput("busy_err", 128'(bus.ia_status[6]), 128'(1));
        checkOutput("busy_last_op", 128'(bus.ia_status[3:0]), 128'(1));
        waitIdle(10);
        checkOutput("busy_rd_data", 128'(bus.ia_rdata), 128'(refMem[5]));
        checkOutput("busy_no_write", 128'(tbMem[6]), 128'(refMem[6]));
        applyStimulus(4'd9, 10'h000, '0);
        checkOutput("illegal_status", 128'(bus.ia_status), 128'(expStatus(1'b1, 4'd1)));
        applyStimulus(4'd0, 10'h000, '0);
        checkOutput("nop_clears_err", 128'(bus.ia_status), 128'(expStatus(1'b0, 4'd0)));

        // INIT sweep with the datapath requesting throughout.
        applyStimulus(4'd3, 10'h000, '0);
        refFifo = 1'b1;
        checkOutput("en_fifo", 128'(bus.fifo_en), 128'(1));
        monitorOn = 1'b1;
        bus.dp_req = 1'b1;
        applyStimulus(4'd5, 10'h000, '0);
        repeat (100) @(negedge clk);
        checkOutput("init_mid_gnt", 128'(bus.dp_gnt), 128'(0));
        checkOutput("init_mid_fifo", 128'(bus.fifo_en), 128'(0));
        waitIdle(2000);
        repeat (3) @(negedge clk);
        refFifo = 1'b0;
        for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
        checkOutput("init_write_count", 128'(sweepWrites), 128'(DEPTH));
        checkOutput("init_bad_writes", 128'(sweepBad), 128'(0));
        checkOutput("init_gaps", 128'(sweepGaps), 128'(0));
        checkOutput("init_gnt_during", 128'(sweepGnt), 128'(0));
        checkOutput("init_fifo_after", 128'(bus.fifo_en), 128'(0));
        checkOutput("init_status", 128'(bus.ia_status), 128'(expStatus(1'b0, 4'd5)));
        monitorOn = 1'b0;
        bus.dp_req = 1'b0;
        addr = AW'($urandom_range(0, DEPTH - 1));
        applyStimulus(4'd1, addr, '0);
        waitIdle(10);
        checkOutput("init_rd_zero", 128'(bus.ia_rdata), 128'(refMem[addr]));

        // Reset in the middle of an INIT sweep.
        data = {$urandom, $urandom, $urandom | 32'h1};
        applyStimulus(4'd2, 10'h007, data);
        waitIdle(10);
        refMem[7] = data;
        applyStimulus(4'd1, 10'h007, '0);
        waitIdle(10);
        checkOutput("pre_rst_rdata", 128'(bus.ia_rdata), 128'(data));
        applyStimulus(4'd3, 10'h000, '0);
        applyStimulus(4'd5, 10'h000, '0);
        found = 1'b0;
        for (int n = 0; n < 2000 && !found; n++) begin
            @(negedge clk);
            if (bus.mem_en === 1'b1 && bus.mem_addr === AW'(300)) found = 1'b1;
        end
        checkOutput("reached_cnt_300", 128'(found), 128'(1));
        rst_n = 1'b0;
        bus.dp_req = 1'b1;
        #1;
        checkOutput("abort_mem_en", 128'(bus.mem_en), 128'(0));
        checkOutput("abort_status", 128'(bus.ia_status), 128'(0));
        checkOutput("abort_rdata", 128'(bus.ia_rdata), 128'(0));
        checkOutput("abort_mem_addr", 128'(bus.mem_addr), 128'(0));
        checkOutput("abort_mem_wdata", 128'(bus.mem_wdata), 128'(0));
        checkOutput("abort_gnt", 128'(bus.dp_gnt), 128'(1));
        @(negedge clk);
        rst_n = 1'b1;
        bus.dp_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("abort_quiet", 128'({bus.mem_en, bus.fifo_en, bus.ia_status}), 128'(0));
        end

        checkOutput("no_gnt_mem_overlap", 128'(overlapViol), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
